pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Combines four sources into per-stage stall and flush controls plus a PC redirect:
  - load-use stall request from the operand-forwarding unit
  - EX branch/jump resolution
  - multi-cycle MUL/DIV busy
  - data-memory wait handshake
- Also sequences trap entry.
- Sits beside the stage registers in the CPU core; every pipeline register takes its stall/flush from this block.

Parameters:
- XLEN, 32, datapath/PC width (from config.v `XLEN).
- MD_MAX_CYCLES, 34, upper bound on MUL/DIV latency before timeout.
- MD_CNT_W, 6, width of the MUL/DIV cycle counter (must hold MD_MAX_CYCLES).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- load_hazerd_stall  in  1  load-use hazard detected for the instruction in ID
- branch_taken_ex  in  1  EX resolved a taken branch/jump
- branch_target_ex  in  XLEN  target of taken branch/jump
- md_start_ex  in  1  multi-cycle MUL/DIV issued in EX this cycle
- md_done  in  1  MUL/DIV result valid
- dmem_req_mem  in  1  MEM stage has an active load/store
- dmem_ack  in  1  data memory completed the access
- trap_req  in  1  trap/interrupt request (level, held until taken)
- trap_vec  in  XLEN  trap handler address
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold stage register
- flush_id, flush_ex, flush_mem, flush_wb  out  1 each  load bubble into stage register
- redirect_en  out  1  load redirect_pc into PC
- redirect_pc  out  XLEN  new PC
- trap_taken  out  1  one-cycle acknowledge of trap entry
- md_timeout  out  1  sticky MUL/DIV timeout error flag

Behaviour:
- Reset: while rst=1:
  - all stall_*=0; all flush_*=1
  - redirect_en=0, redirect_pc=0, trap_taken=0, md_timeout=0
  - state=RUN, counter=0, pending trap cleared
- Takes effect at the next clk edge.
- FSM states: RUN, MEM_WAIT, MD_WAIT, TRAP. Outputs are combinational from state plus inputs. State, counter and the trap_vec latch are registered.
- Priority in RUN, highest first: memory wait > trap > MUL/DIV wait > branch > load-use.
- RUN, dmem_req_mem=1 and dmem_ack=0:
  - stall_if/id/ex/mem=1, flush_wb=1
  - next state MEM_WAIT
  - dmem_req_mem with dmem_ack in the same cycle causes no stall.
- MEM_WAIT:
  - same outputs as above until dmem_ack=1
  - on the ack cycle all stalls drop and flush_wb=0; next state RUN
  - trap_req and branch_taken_ex are ignored while waiting; they are still asserted (held) after return to RUN.
- RUN, trap_req=1:
  - flush_id/ex/mem=1, redirect_en=1, redirect_pc=trap_vec, trap_taken=1, all in the same cycle
  - next state TRAP
- TRAP (1 cycle):
  - flush_id=1 (squashes the fetch already in flight); no redirect
  - next state RUN
  - trap_req is ignored in TRAP; the requester must drop it after trap_taken.
- RUN, md_start_ex=1 and md_done=0:
  - stall_if/id/ex=1, flush_mem=1
  - counter cleared to 1; next state MD_WAIT
  - md_done in the same cycle as md_start_ex causes no stall.
- MD_WAIT:
  - stall_if/id/ex=1, flush_mem=1; counter increments each cycle
  - on md_done=1: outputs released this cycle; next state RUN
  - if counter reaches MD_MAX_CYCLES without md_done: md_timeout<=1 (sticky until rst), release stalls, return to RUN
- RUN, branch_taken_ex=1:
  - flush_id=1, flush_ex=1, redirect_en=1, redirect_pc=branch_target_ex
  - a simultaneous load_hazerd_stall is ignored (its ID instruction is squashed)
- RUN, load_hazerd_stall only:
  - stall_if=1, stall_id=1, flush_ex=1 for exactly the cycles it is high; no state change
- Counter saturates; no wrap. redirect_pc is 0 whenever redirect_en=0.
- rst during any wait state returns to RUN with the reset outputs above; a pending access or MUL/DIV is abandoned.

Decomposition:
- config.v gains:
  - state encodings `PHC_RUN/`PHC_MEM_WAIT/`PHC_MD_WAIT/`PHC_TRAP (2-bit)
  - `MD_MAX_CYCLES
  - reuse of `TURE/`FALSE/`ZERO_32BIT
- One sub-module, md_wait_cnt: saturating cycle counter with clear/enable and a terminal-count output, used for the MD_WAIT timeout.

Test Plan:
1. Load-use: load_hazerd_stall=1 for 1 cycle in RUN -> stall_if=stall_id=flush_ex=1 that cycle only; redirect_en=0.
2. Branch + load-use same cycle, branch_target_ex=0x0000_0100 -> flush_id=flush_ex=1, redirect_en=1, redirect_pc=0x100, stall_if=0.
3. MEM wait: dmem_req_mem=1, dmem_ack rises after 3 cycles -> all four stalls plus flush_wb held 3 cycles, released on the ack cycle; trap_req asserted mid-wait is taken with trap_taken=1 on the first RUN cycle.
4. MUL/DIV: md_start_ex=1, md_done after 10 cycles -> stall_if/id/ex plus flush_mem for 10 cycles, md_timeout=0.
5. Timeout: md_start_ex=1, md_done never asserted -> release after MD_MAX_CYCLES=34 cycles, md_timeout=1 stays high until rst.
6. Reset mid-MD_WAIT at cycle 5 -> next cycle all stalls 0, all flushes 1, md_timeout=0, state RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, per-stage control bundle
// and default sizing.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned XlenDef        = 32;
    localparam int unsigned MdMaxCyclesDef = 34;
    localparam int unsigned MdCntWDef      = 6;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StMdWait  = 2'd2,
        StTrap    = 2'd3
    } phc_state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
        logic flush_wb;
    } pipe_ctrl_t;

    // Reset loads a bubble into every stage register and holds nothing.
    function automatic pipe_ctrl_t reset_ctrl();
        pipe_ctrl_t c;
        c           = '0;
        c.flush_id  = 1'b1;
        c.flush_ex  = 1'b1;
        c.flush_mem = 1'b1;
        c.flush_wb  = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_wait_cnt.sv
// Saturating cycle counter for MUL/DIV waits; clear loads 1 so the issue cycle is counted.
module md_wait_cnt #(
    parameter int unsigned Width    = 6,
    parameter int unsigned MaxCount = 34
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = Width'(1);
        end else if (en && !tc) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == Width'(MaxCount));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges memory wait, trap entry,
// MUL/DIV wait, branch redirect and load-use stall into per-stage controls.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned XLEN          = XlenDef,
    parameter int unsigned MD_MAX_CYCLES = MdMaxCyclesDef,
    parameter int unsigned MD_CNT_W      = MdCntWDef
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_hazerd_stall,
    input  logic            branch_taken_ex,
    input  logic [XLEN-1:0] branch_target_ex,
    input  logic            md_start_ex,
    input  logic            md_done,
    input  logic            dmem_req_mem,
    input  logic            dmem_ack,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vec,
    output logic            stall_if,
    output logic            stall_id,
    output logic            stall_ex,
    output logic            stall_mem,
    output logic            flush_id,
    output logic            flush_ex,
    output logic            flush_mem,
    output logic            flush_wb,
    output logic            redirect_en,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_taken,
    output logic            md_timeout
);

    phc_state_e state_q, state_d;
    pipe_ctrl_t ctrl;
    logic       md_timeout_q;
    logic       timeout_set;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_tc;

    md_wait_cnt #(
        .Width    (MD_CNT_W),
        .MaxCount (MD_MAX_CYCLES)
    ) u_md_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_comb begin
        ctrl        = '0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        trap_taken  = 1'b0;
        state_d     = state_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        timeout_set = 1'b0;

        if (rst) begin
            ctrl    = reset_ctrl();
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (dmem_req_mem && !dmem_ack) begin
                        ctrl.stall_if  = 1'b1;
                        ctrl.stall_id  = 1'b1;
                        ctrl.stall_ex  = 1'b1;
                        ctrl.stall_mem = 1'b1;
                        ctrl.flush_wb  = 1'b1;
                        state_d        = StMemWait;
                    end else if (trap_req) begin
                        ctrl.flush_id  = 1'b1;
                        ctrl.flush_ex  = 1'b1;
                        ctrl.flush_mem = 1'b1;
                        redirect_en    = 1'b1;
                        redirect_pc    = trap_vec;
                        trap_taken     = 1'b1;
                        state_d        = StTrap;
                    end else if (md_start_ex && !md_done) begin
                        ctrl.stall_if  = 1'b1;
                        ctrl.stall_id  = 1'b1;
                        ctrl.stall_ex  = 1'b1;
                        ctrl.flush_mem = 1'b1;
                        cnt_clr        = 1'b1;
                        state_d        = StMdWait;
                    end else if (branch_taken_ex) begin
                        // A concurrent load-use stall is moot: its ID instruction is squashed.
                        ctrl.flush_id = 1'b1;
                        ctrl.flush_ex = 1'b1;
                        redirect_en   = 1'b1;
                        redirect_pc   = branch_target_ex;
                    end else if (load_hazerd_stall) begin
                        ctrl.stall_if = 1'b1;
                        ctrl.stall_id = 1'b1;
                        ctrl.flush_ex = 1'b1;
                    end
                end
                StMemWait: begin
                    if (dmem_ack) begin
                        state_d = StRun;
                    end else begin
                        ctrl.stall_if  = 1'b1;
                        ctrl.stall_id  = 1'b1;
                        ctrl.stall_ex  = 1'b1;
                        ctrl.stall_mem = 1'b1;
                        ctrl.flush_wb  = 1'b1;
                    end
                end
                StMdWait: begin
                    if (md_done) begin
                        state_d = StRun;
                    end else if (cnt_tc) begin
                        timeout_set = 1'b1;
                        state_d     = StRun;
                    end else begin
                        ctrl.stall_if  = 1'b1;
                        ctrl.stall_id  = 1'b1;
                        ctrl.stall_ex  = 1'b1;
                        ctrl.flush_mem = 1'b1;
                        cnt_en         = 1'b1;
                    end
                end
                StTrap: begin
                    // Squash the fetch that was already in flight when the redirect issued.
                    ctrl.flush_id = 1'b1;
                    state_d       = StRun;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            md_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (timeout_set) begin
                md_timeout_q <= 1'b1;
            end
        end
    end

    assign stall_if   = ctrl.stall_if;
    assign stall_id   = ctrl.stall_id;
    assign stall_ex   = ctrl.stall_ex;
    assign stall_mem  = ctrl.stall_mem;
    assign flush_id   = ctrl.flush_id;
    assign flush_ex   = ctrl.flush_ex;
    assign flush_mem  = ctrl.flush_mem;
    assign flush_wb   = ctrl.flush_wb;
    assign md_timeout = md_timeout_q && !rst;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle vector table plus multi-cycle wait,
// timeout and reset sequences.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        load_hazerd_stall;
    logic        branch_taken_ex;
    logic [31:0] branch_target_ex;
    logic        md_start_ex;
    logic        md_done;
    logic        dmem_req_mem;
    logic        dmem_ack;
    logic        trap_req;
    logic [31:0] trap_vec;
    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        flush_id, flush_ex, flush_mem, flush_wb;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        trap_taken;
    logic        md_timeout;

    int n_checks = 0;
    int n_fails  = 0;

    pipe_hazard_ctrl #(
        .XLEN          (32),
        .MD_MAX_CYCLES (34),
        .MD_CNT_W      (6)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .load_hazerd_stall (load_hazerd_stall),
        .branch_taken_ex   (branch_taken_ex),
        .branch_target_ex  (branch_target_ex),
        .md_start_ex       (md_start_ex),
        .md_done           (md_done),
        .dmem_req_mem      (dmem_req_mem),
        .dmem_ack          (dmem_ack),
        .trap_req          (trap_req),
        .trap_vec          (trap_vec),
        .stall_if          (stall_if),
        .stall_id          (stall_id),
        .stall_ex          (stall_ex),
        .stall_mem         (stall_mem),
        .flush_id          (flush_id),
        .flush_ex          (flush_ex),
        .flush_mem         (flush_mem),
        .flush_wb          (flush_wb),
        .redirect_en       (redirect_en),
        .redirect_pc       (redirect_pc),
        .trap_taken        (trap_taken),
        .md_timeout        (md_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall if/id/ex/mem, flush id/ex/mem/wb, redirect_en, redirect_pc, trap_taken, md_timeout}
    logic [42:0] outs;
    assign outs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem,
                   flush_wb, redirect_en, redirect_pc, trap_taken, md_timeout};

    typedef struct {
        string       name;
        logic        lh, bt, mds, mdd, dreq, dack, treq;
        logic [31:0] target, tvec;
        logic [3:0]  stall, flush;
        logic        ren;
        logic [31:0] rpc;
        logic        tt, mto;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [42:0] exp_o(logic [3:0] s, logic [3:0] f, logic ren,
                                          logic [31:0] pc, logic tt, logic mto);
        return {s, f, ren, pc, tt, mto};
    endfunction

    task automatic check(input string name, input logic [42:0] exp);
        n_checks++;
        if (outs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h required %h", name, outs, exp);
        end
    endtask

    task automatic set_in(input logic lh, input logic bt, input logic [31:0] tgt,
                          input logic mds, input logic mdd, input logic dreq,
                          input logic dack, input logic treq, input logic [31:0] tv);
        load_hazerd_stall = lh;
        branch_taken_ex   = bt;
        branch_target_ex  = tgt;
        md_start_ex       = mds;
        md_done           = mdd;
        dmem_req_mem      = dreq;
        dmem_ack          = dack;
        trap_req          = treq;
        trap_vec          = tv;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    localparam logic [42:0] IDLE  = 43'd0;
    localparam logic [42:0] RESET = {4'b0000, 4'b1111, 1'b0, 32'd0, 1'b0, 1'b0};
    localparam logic [42:0] MEMST = {4'b1111, 4'b0001, 1'b0, 32'd0, 1'b0, 1'b0};
    localparam logic [42:0] MDST  = {4'b1110, 4'b0010, 1'b0, 32'd0, 1'b0, 1'b0};

    initial begin
        int stalls;
        logic [42:0] e;

        vecs[0] = '{"idle",       0,0,0,0,0,0,0, 32'h0,     32'h0,         4'b0000,4'b0000,0,32'h0,0,0};
        vecs[1] = '{"load_use",   1,0,0,0,0,0,0, 32'h0,     32'h0,         4'b1100,4'b0100,0,32'h0,0,0};
        vecs[2] = '{"lu_drop",    0,0,0,0,0,0,0, 32'h0,     32'h0,         4'b0000,4'b0000,0,32'h0,0,0};
        vecs[3] = '{"br_plus_lu", 1,1,0,0,0,0,0, 32'h100,   32'h0,         4'b0000,4'b1100,1,32'h100,0,0};
        vecs[4] = '{"mem_ack_0",  0,0,0,0,1,1,0, 32'h0,     32'h0,         4'b0000,4'b0000,0,32'h0,0,0};
        vecs[5] = '{"md_done_0",  0,0,1,1,0,0,0, 32'h0,     32'h0,         4'b0000,4'b0000,0,32'h0,0,0};
        vecs[6] = '{"trap_enter", 0,0,0,0,0,0,1, 32'h0,     32'h8000_0040, 4'b0000,4'b1110,1,32'h8000_0040,1,0};
        vecs[7] = '{"trap_state", 1,0,0,0,0,0,1, 32'h0,     32'h8000_0040, 4'b0000,4'b1000,0,32'h0,0,0};
        vecs[8] = '{"rpc_zero",   0,0,0,0,0,0,0, 32'hdead,  32'h0,         4'b0000,4'b0000,0,32'h0,0,0};
        vecs[9] = '{"ack_lu",     1,0,0,0,1,1,0, 32'h0,     32'h0,         4'b1100,4'b0100,0,32'h0,0,0};

        rst = 1'b1;
        set_in(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        cyc(); #1 check("reset_0", RESET);
        cyc(); #1 check("reset_1", RESET);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cyc();
            set_in(vecs[i].lh, vecs[i].bt, vecs[i].target, vecs[i].mds, vecs[i].mdd,
                   vecs[i].dreq, vecs[i].dack, vecs[i].treq, vecs[i].tvec);
            #1 check(vecs[i].name, exp_o(vecs[i].stall, vecs[i].flush, vecs[i].ren,
                                         vecs[i].rpc, vecs[i].tt, vecs[i].mto));
        end

        // Memory wait of 3 cycles with trap and branch arriving mid-wait.
        cyc(); set_in(0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0);
        #1 check("mem_wait_0", MEMST);
        cyc(); set_in(0, 0, 32'h0, 0, 0, 1, 0, 1, 32'h0000_0200);
        #1 check("mem_wait_1_trap_ign", MEMST);
        cyc(); set_in(0, 1, 32'h300, 0, 0, 1, 0, 1, 32'h0000_0200);
        #1 check("mem_wait_2_br_ign", MEMST);
        cyc(); set_in(0, 1, 32'h300, 0, 0, 1, 1, 1, 32'h0000_0200);
        #1 check("mem_ack_release", IDLE);
        cyc(); set_in(0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h0000_0200);
        #1 check("trap_after_mem", exp_o(4'b0000, 4'b1110, 1, 32'h200, 1, 0));
        cyc(); set_in(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        #1 check("trap_squash", exp_o(4'b0000, 4'b1000, 0, 32'h0, 0, 0));

        // MUL/DIV completing after 10 stalled cycles.
        stalls = 0;
        cyc(); set_in(0, 0, 32'h0, 1, 0, 0, 0, 0, 32'h0);
        #1 if (outs == MDST) stalls++;
        for (int k = 1; k < 10; k++) begin
            cyc(); set_in(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
            #1 if (outs == MDST) stalls++;
        end
        n_checks++;
        if (stalls != 10) begin
            n_fails++;
            $display("FAIL md_stall_count: got %0d required 10", stalls);
        end
        cyc(); set_in(0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0);
        #1 check("md_done_release", IDLE);
        cyc(); set_in(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        #1 check("md_no_timeout", IDLE);

        // MUL/DIV that never completes: 34 stalled cycles, then release and sticky timeout.
        stalls = 0;
        cyc(); set_in(0, 0, 32'h0, 1, 0, 0, 0, 0, 32'h0);
        #1 if (outs == MDST) stalls++;
        for (int k = 1; k < 34; k++) begin
            cyc(); set_in(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
            #1 if (outs == MDST) stalls++;
        end
        n_checks++;
        if (stalls != 34) begin
            n_fails++;
            $display("FAIL md_timeout_stalls: got %0d required 34", stalls);
        end
        cyc(); #1 check("md_timeout_release", IDLE);
        e = exp_o(4'b0000, 4'b0000, 0, 32'h0, 0, 1);
        cyc(); #1 check("md_timeout_set", e);
        cyc(); set_in(0, 0, 32'h0, 1, 1, 0, 0, 0, 32'h0);
        #1 check("md_timeout_sticky", e);
        cyc(); set_in(1, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        #1 check("md_timeout_lu", exp_o(4'b1100, 4'b0100, 0, 32'h0, 0, 1));
        cyc(); set_in(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        rst = 1'b1;
        #1 check("timeout_rst", RESET);
        cyc(); rst = 1'b0;
        #1 check("timeout_cleared", IDLE);

        // Reset at the fifth cycle of an MD wait abandons it.
        cyc(); set_in(0, 0, 32'h0, 1, 0, 0, 0, 0, 32'h0);
        #1 check("md_rst_start", MDST);
        for (int k = 1; k < 5; k++) begin
            cyc(); set_in(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        end
        #1 check("md_rst_waiting", MDST);
        cyc(); rst = 1'b1;
        #1 check("md_rst_asserted", RESET);
        cyc();
        #1 check("md_rst_next", RESET);
        cyc(); rst = 1'b0;
        #1 check("md_rst_run", IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
